// File: rtl/rop3_pkg.sv
// -----------------------------------------------------------------------------
// rop3_pkg
// Shared definitions for the ROP3 serial operand interface:
//   - state_e      : transmit FSM state encoding (3-bit)
//   - ROP_*        : the ROP3 mode codes the reference ALU understands
//   - RSP_TIMEOUT_DFLT : default number of cycles to wait for an engine response
// -----------------------------------------------------------------------------
package rop3_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SEND_P   = 3'd1,
      ST_SEND_S   = 3'd2,
      ST_SEND_D   = 3'd3,
      ST_WAIT_RSP = 3'd4
   } state_e;

   // ROP3 mode codes (truth-table byte indexed by {P,S,D})
   localparam logic [7:0] ROP_BLACKNESS   = 8'h00;
   localparam logic [7:0] ROP_NOTSRCERASE = 8'h11;
   localparam logic [7:0] ROP_NOTSRCCOPY  = 8'h33;
   localparam logic [7:0] ROP_SRCERASE    = 8'h44;
   localparam logic [7:0] ROP_DSTINVERT   = 8'h55;
   localparam logic [7:0] ROP_PATINVERT   = 8'h5A;
   localparam logic [7:0] ROP_SRCINVERT   = 8'h66;
   localparam logic [7:0] ROP_SRCAND      = 8'h88;
   localparam logic [7:0] ROP_MERGEPAINT  = 8'hBB;
   localparam logic [7:0] ROP_MERGECOPY   = 8'hC0;
   localparam logic [7:0] ROP_SRCCOPY     = 8'hCC;
   localparam logic [7:0] ROP_SRCPAINT    = 8'hEE;
   localparam logic [7:0] ROP_PATCOPY     = 8'hF0;
   localparam logic [7:0] ROP_PATPAINT    = 8'hFB;
   localparam logic [7:0] ROP_WHITENESS   = 8'hFF;

   localparam int RSP_TIMEOUT_DFLT = 15;

endpackage

// File: rtl/rop3_ref_alu.sv
// -----------------------------------------------------------------------------
// rop3_ref_alu
// Combinational reference ROP3 evaluator used by the optional response checker.
// Only the modes listed in rop3_pkg are evaluated; any other mode yields 0.
// Ports:
//   p, s, d : pattern / source / destination operands (N bits)
//   mode    : ROP3 mode code
//   result  : expected engine result (N bits)
// -----------------------------------------------------------------------------
module rop3_ref_alu
   import rop3_pkg::*;
#(
   parameter int N = 8
) (
   input  logic [N-1:0] p,
   input  logic [N-1:0] s,
   input  logic [N-1:0] d,
   input  logic [7:0]   mode,
   output logic [N-1:0] result
);

   // Map each supported mode code to its bitwise boolean expression
   always_comb begin
      result = {N{1'b0}};
      case (mode)
         ROP_BLACKNESS:   result = {N{1'b0}};
         ROP_NOTSRCERASE: result = ~(s | d);
         ROP_NOTSRCCOPY:  result = ~s;
         ROP_SRCERASE:    result = s & ~d;
         ROP_DSTINVERT:   result = ~d;
         ROP_PATINVERT:   result = p ^ d;
         ROP_SRCINVERT:   result = s ^ d;
         ROP_SRCAND:      result = s & d;
         ROP_MERGEPAINT:  result = ~s | d;
         ROP_MERGECOPY:   result = p & s;
         ROP_SRCCOPY:     result = s;
         ROP_SRCPAINT:    result = s | d;
         ROP_PATCOPY:     result = p;
         ROP_PATPAINT:    result = p | ~s | d;
         ROP_WHITENESS:   result = {N{1'b1}};
         default:         result = {N{1'b0}};
      endcase
   end

endmodule

// File: rtl/rop3_frame_tx.sv
// -----------------------------------------------------------------------------
// rop3_frame_tx
// Accepts one {P,S,D,Mode} job over a valid/ready handshake, serialises P, S, D
// onto Bitmap on three consecutive cycles (Mode held for the whole frame), then
// waits up to RSP_TIMEOUT cycles for the engine response and returns it
// upstream, or pulses out_timeout.
// Optional build macro ROP3_FRAME_CHECK_EN adds out_mismatch, which pulses with
// out_valid when the engine result differs from a locally computed ROP3.
// Ports:
//   clk, srst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready      : job handshake; in_p/in_s/in_d/in_mode job fields
//   Bitmap, Mode           : serial operand bus and mode code to the engine
//   frame_start            : high in the cycle Bitmap carries P
//   rsp_valid, rsp_result  : engine response
//   out_valid, out_result  : returned result (result held between events)
//   out_timeout            : no response in time
//   out_mismatch           : (optional) result differs from reference ROP3
//   busy                   : FSM not idle
// -----------------------------------------------------------------------------
module rop3_frame_tx
   import rop3_pkg::*;
#(
   parameter int N           = 8,
   parameter int RSP_TIMEOUT = RSP_TIMEOUT_DFLT
) (
   input  logic         clk,
   input  logic         srst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_p,
   input  logic [N-1:0] in_s,
   input  logic [N-1:0] in_d,
   input  logic [7:0]   in_mode,
   output logic [N-1:0] Bitmap,
   output logic [7:0]   Mode,
   output logic         frame_start,
   input  logic         rsp_valid,
   input  logic [N-1:0] rsp_result,
   output logic         out_valid,
   output logic [N-1:0] out_result,
   output logic         out_timeout,
`ifdef ROP3_FRAME_CHECK_EN
   output logic         out_mismatch,
`endif
   output logic         busy
);

   localparam int CW = $clog2(RSP_TIMEOUT + 1);
   // Last counter value before the wait budget is exhausted
   localparam logic [CW-1:0] CNT_LAST = CW'(RSP_TIMEOUT - 32'sd1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(32'sd1);

   state_e         state_r, state_s;
   logic [N-1:0]   p_r, s_r, d_r, p_s, s_s, d_s;
   logic [7:0]     mode_r, mode_s;
   logic [CW-1:0]  cnt_r, cnt_s;
   logic [N-1:0]   bitmap_r, bitmap_s;
   logic [7:0]     mode_out_r, mode_out_s;
   logic           frame_start_r, frame_start_s;
   logic           busy_r, busy_s;
   logic           out_valid_r, out_valid_s;
   logic           out_timeout_r, out_timeout_s;
   logic [N-1:0]   result_r, result_s;

   // Next-state, operand latch and registered-output decode
   always_comb begin
      state_s       = state_r;
      p_s           = p_r;
      s_s           = s_r;
      d_s           = d_r;
      mode_s        = mode_r;
      cnt_s         = cnt_r;
      result_s      = result_r;
      out_valid_s   = 1'b0;
      out_timeout_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (in_valid) begin
               p_s     = in_p;
               s_s     = in_s;
               d_s     = in_d;
               mode_s  = in_mode;
               state_s = ST_SEND_P;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_SEND_P: state_s = ST_SEND_S;
         ST_SEND_S: state_s = ST_SEND_D;
         ST_SEND_D: begin
            cnt_s   = {CW{1'b0}};
            state_s = ST_WAIT_RSP;
         end
         ST_WAIT_RSP: begin
            // A response on the final allowed cycle takes priority over timeout
            if (rsp_valid) begin
               result_s    = rsp_result;
               out_valid_s = 1'b1;
               state_s     = ST_IDLE;
            end else if (cnt_r == CNT_LAST) begin
               result_s      = {N{1'b0}};
               out_timeout_s = 1'b1;
               state_s       = ST_IDLE;
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end
         default: state_s = ST_IDLE;
      endcase

      // Outputs are decoded from the next state so they align with state_r
      case (state_s)
         ST_SEND_P: bitmap_s = p_s;
         ST_SEND_S: bitmap_s = s_s;
         ST_SEND_D: bitmap_s = d_s;
         default:   bitmap_s = {N{1'b0}};
      endcase
      mode_out_s    = (state_s != ST_IDLE) ? mode_s : 8'h00;
      frame_start_s = (state_s == ST_SEND_P);
      busy_s        = (state_s != ST_IDLE);
   end

   // State, operand latches and registered outputs
   always_ff @(posedge clk or negedge srst_n) begin
      if (!srst_n) begin
         state_r       <= ST_IDLE;
         p_r           <= {N{1'b0}};
         s_r           <= {N{1'b0}};
         d_r           <= {N{1'b0}};
         mode_r        <= 8'h00;
         cnt_r         <= {CW{1'b0}};
         bitmap_r      <= {N{1'b0}};
         mode_out_r    <= 8'h00;
         frame_start_r <= 1'b0;
         busy_r        <= 1'b0;
         out_valid_r   <= 1'b0;
         out_timeout_r <= 1'b0;
         result_r      <= {N{1'b0}};
      end else begin
         state_r       <= state_s;
         p_r           <= p_s;
         s_r           <= s_s;
         d_r           <= d_s;
         mode_r        <= mode_s;
         cnt_r         <= cnt_s;
         bitmap_r      <= bitmap_s;
         mode_out_r    <= mode_out_s;
         frame_start_r <= frame_start_s;
         busy_r        <= busy_s;
         out_valid_r   <= out_valid_s;
         out_timeout_r <= out_timeout_s;
         result_r      <= result_s;
      end
   end

   assign in_ready    = (state_r == ST_IDLE);
   assign Bitmap      = bitmap_r;
   assign Mode        = mode_out_r;
   assign frame_start = frame_start_r;
   assign busy        = busy_r;
   assign out_valid   = out_valid_r;
   assign out_timeout = out_timeout_r;
   assign out_result  = result_r;

`ifdef ROP3_FRAME_CHECK_EN
   logic [N-1:0] expect_s;
   logic         mismatch_r;

   rop3_ref_alu #(.N(N)) u_ref_alu (
      .p      (p_r),
      .s      (s_r),
      .d      (d_r),
      .mode   (mode_r),
      .result (expect_s)
   );

   // Compare the engine result against the reference only when it is captured
   always_ff @(posedge clk or negedge srst_n) begin
      if (!srst_n) begin
         mismatch_r <= 1'b0;
      end else begin
         mismatch_r <= (state_r == ST_WAIT_RSP) && rsp_valid && (rsp_result != expect_s);
      end
   end

   assign out_mismatch = mismatch_r;
`endif

endmodule

// File: doc/rop3_frame_tx.md
Name: rop3_frame_tx

Overview:
Transmit side of the ROP3 serial operand interface. It accepts one {P, S, D, Mode} job in parallel through a valid/ready handshake and serialises the operands onto the Bitmap bus over three consecutive cycles, holding Mode stable. It then waits for the ROP3 engine's valid/Result response and returns the result upstream, or flags a timeout if none arrives. It sits between the test/host sequencer and the ROP3 engine.

Parameters:
N, 8, bit-length of the P/S/D operands, Bitmap and Result.
RSP_TIMEOUT, 15, maximum number of WAIT_RSP cycles before a timeout; legal range >= 1.

Ports:
clk  input  1  clock; all state updates on the rising edge.
srst_n  input  1  reset, asynchronous assert, active-low.
in_valid  input  1  upstream job valid.
in_ready  output  1  job accepted at a clock edge where in_valid & in_ready.
in_p  input  N  pattern operand.
in_s  input  N  source operand.
in_d  input  N  destination operand.
in_mode  input  8  ROP3 mode code.
Bitmap  output  N  serial operand bus to the engine.
Mode  output  8  mode code to the engine.
frame_start  output  1  high during the cycle Bitmap carries P.
rsp_valid  input  1  engine result valid.
rsp_result  input  N  engine result.
out_valid  output  1  one-cycle pulse: out_result is valid.
out_result  output  N  captured result; held until the next out_valid or out_timeout.
out_timeout  output  1  one-cycle pulse: no response within RSP_TIMEOUT cycles.
busy  output  1  high whenever state != IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset is srst_n, asynchronous and active-low.
- Reset values: state IDLE; Bitmap, Mode, out_result and the operand latches 0; frame_start, out_valid, out_timeout and busy 0. in_ready = (state==IDLE), so it reads 1 while reset is held.
- FSM states: IDLE, SEND_P, SEND_S, SEND_D, WAIT_RSP.
- IDLE: on in_valid, latch in_p/in_s/in_d/in_mode and go to SEND_P. Otherwise stay. in_ready is 0 in every other state.
- SEND_P -> SEND_S -> SEND_D -> WAIT_RSP, unconditionally, one cycle each.
- Bitmap output by state: SEND_P = latched P, SEND_S = latched S, SEND_D = latched D, all other states = 0.
- Bitmap, Mode and frame_start are registered outputs, valid in the same cycle the state register shows the matching SEND state.
- Mode carries the latched mode from SEND_P until the cycle WAIT_RSP exits. It is 0 in IDLE.
- Acceptance latency: job accepted at edge k -> Bitmap = P in cycle k+1, S in k+2, D in k+3. WAIT_RSP begins at k+4.
- WAIT_RSP: a counter of width $clog2(RSP_TIMEOUT+1) is cleared on entry.
  - rsp_valid high: capture rsp_result into out_result, pulse out_valid on the next cycle, go to IDLE.
  - rsp_valid low: counter increments. When the counter == RSP_TIMEOUT-1 and rsp_valid is low, go to IDLE, set out_result = 0 and pulse out_timeout.
  - rsp_valid on the final allowed cycle wins over the timeout.
- rsp_valid outside WAIT_RSP is ignored and leaves no side effects.
- Back-to-back jobs: minimum period is 5 cycles, because IDLE is re-entered for 1 cycle before the next acceptance.
- Reset mid-frame: immediate return to IDLE with all outputs at reset values. The partial frame is abandoned and produces no out_valid or out_timeout.
- Job inputs are sampled only at acceptance. Changes to in_* during a frame have no effect.

Optional Feature:
Macro ROP3_FRAME_CHECK_EN.
- Defined:
  - Adds output out_mismatch (1 bit), a one-cycle pulse coincident with out_valid.
  - The pulse fires when rsp_result differs from a locally computed expected ROP3 of the latched P/S/D/mode.
  - The expected value covers modes 00, 11, 33, 44, 55, 5A, 66, 88, BB, C0, CC, EE, F0, FB and FF. Any other mode expects 0.
  - out_mismatch is 0 on timeout and after reset.
- Undefined: the port and the checker logic are absent.

Decomposition:
- Package rop3_pkg holds:
  - the state enumeration (3-bit);
  - localparams for the 15 mode codes;
  - a default-timeout constant.
- One sub-module, rop3_ref_alu (combinational, N-parameterised, mode -> result), instantiated only under ROP3_FRAME_CHECK_EN.

Test Plan:
- Single job, normal response:
  - Stimulus: in_p=A5, in_s=3C, in_d=0F, in_mode=F0; rsp_valid with rsp_result=A5 two cycles after SEND_D.
  - Required: Bitmap sequence A5, 3C, 0F; frame_start high only with A5; Mode=F0 throughout the frame; out_valid pulse with out_result=A5; busy drops afterwards.
- Timeout:
  - Stimulus: RSP_TIMEOUT=15, rsp_valid never asserted.
  - Required: exactly 15 WAIT_RSP cycles, then out_timeout pulse with out_result=00; in_ready high on the next cycle.
- Last-cycle response:
  - Stimulus: rsp_valid with rsp_result=5A asserted in the 15th WAIT_RSP cycle.
  - Required: out_valid and out_result=5A; no out_timeout.
- Back-to-back with a stray response:
  - Stimulus: in_valid held high with two jobs; a stray rsp_valid during SEND_S.
  - Required: the stray is ignored; second acceptance occurs 1 cycle after the first frame's IDLE re-entry; the two frames do not overlap.
- Reset mid-frame:
  - Stimulus: srst_n low during SEND_S.
  - Required: Bitmap=0, Mode=0, busy=0 asynchronously; no out_valid or out_timeout after release; in_ready=1.
- Checker (ROP3_FRAME_CHECK_EN defined):
  - Stimulus: mode=5A, P=F0, D=3C, rsp_result=CD.
  - Required: out_mismatch=1, since the expected value is CC.
  - Stimulus: same job with rsp_result=CC.
  - Required: out_mismatch=0.
